// File: rtl/ddma_req_scheduler_pkg.sv
// Shared types and constants for the dDMA request scheduler: FSM encoding,
// descriptor layout and the watchdog width helper.
package ddma_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    localparam int DESC_W        = 97;
    localparam int ADDR_W        = 32;
    localparam int LEN_W         = 16;
    localparam int ADDR_RAM_LSB  = 0;
    localparam int LEN_RAM_LSB   = 32;
    localparam int ADDR_AIPE_LSB = 48;
    localparam int LEN_AIPE_LSB  = 80;
    localparam int DIR_BIT       = 96;

    localparam logic DIR_RAM2AIPE = 1'b0;
    localparam logic DIR_AIPE2RAM = 1'b1;

    // Field order mirrors the bit offsets above (MSB first).
    typedef struct packed {
        logic              dir;
        logic [LEN_W-1:0]  len_aipe;
        logic [ADDR_W-1:0] addr_aipe;
        logic [LEN_W-1:0]  len_ram;
        logic [ADDR_W-1:0] addr_ram;
    } desc_t;

    function automatic int wd_width(input int timeout_cyc);
        int w;
        w = $clog2(timeout_cyc + 1);
        if (w < 16) begin
            w = 16;
        end else if (w > 32) begin
            w = 32;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/ddma_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: search begins at the slot after the last grant;
// the pointer moves only when the caller consumes the grant.
module rr_arbiter #(
    parameter int NUM_PE = 3,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_PE-1:0] req,
    input  logic              advance,
    output logic [NUM_PE-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic [IDX_W:0]   cand_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Rotating priority search over the request vector.
    always_comb begin
        idx_s      = '0;
        found_s    = 1'b0;
        cand_s     = '0;
        cand_idx_s = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            cand_s = {1'b0, ptr_r} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(NUM_PE)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_PE);
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = cand_s[IDX_W-1:0];
            if (!found_s && req[cand_idx_s]) begin
                found_s = 1'b1;
                idx_s   = cand_idx_s;
            end else begin
                found_s = found_s;
            end
        end
        if (idx_s == IDX_W'(NUM_PE - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = idx_s + IDX_W'(1);
        end
    end

    assign grant     = found_s ? (NUM_PE'(1) << idx_s) : '0;
    assign grant_idx = idx_s;

    // Pointer register: next search starts one past the consumed grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance && found_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/ddma_req_scheduler.sv
// Shares one dDMA engine among NUM_PE requesters: per-PE descriptor slots,
// round-robin grant, toggle handshake to the engine and a busy watchdog.
module ddma_req_scheduler
    import ddma_sched_pkg::*;
#(
    parameter int NUM_PE      = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_PE-1:0]        i_req_valid,
    output logic [NUM_PE-1:0]        o_req_ready,
    input  logic [NUM_PE*DESC_W-1:0] i_req_desc,
    output logic                     o_tag_start_dDMA,
    input  logic                     i_tag_resp_dDMA,
    output logic [31:0]              o_addr_RAM,
    output logic [15:0]              o_len_RAM,
    output logic [31:0]              o_addr_RAM_AIPE,
    output logic [15:0]              o_len_RAM_AIPE,
    output logic                     o_dir,
    output logic [NUM_PE-1:0]        o_done,
    output logic [NUM_PE-1:0]        o_err_timeout,
    input  logic                     i_clr_err,
    output logic [2:0]               d_state_3b,
    output logic [1:0]               d_cur_pe_2b
);

    localparam int IDX_W = $clog2(NUM_PE);
    localparam int WD_W  = wd_width(TIMEOUT_CYC);
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    state_e            state_r, state_nxt_s;
    desc_t             slot_r [NUM_PE];
    desc_t             desc_in_s [NUM_PE];
    logic [NUM_PE-1:0] full_r;
    logic [NUM_PE-1:0] ready_s;
    logic [NUM_PE-1:0] grant_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic [IDX_W-1:0]  cur_r;
    desc_t             out_desc_r;
    logic              tag_r;
    logic [WD_W-1:0]   wd_r;
    logic [NUM_PE-1:0] done_r, done_nxt_s;
    logic [NUM_PE-1:0] err_r, err_nxt_s;
    logic              zero_len_s;
    logic              resp_match_s;
    logic              timeout_hit_s;

    // Unpack the flat descriptor bus into per-PE structs.
    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            desc_in_s[i] = i_req_desc[i*DESC_W +: DESC_W];
        end
    end

    assign ready_s       = ~full_r & {NUM_PE{state_r != ST_HALT}};
    assign zero_len_s    = (slot_r[grant_idx_s].len_ram == 16'd0) && (slot_r[grant_idx_s].len_aipe == 16'd0);
    assign resp_match_s  = (i_tag_resp_dDMA == tag_r);
    assign timeout_hit_s = WD_EN && (wd_r == WD_LAST);

    rr_arbiter #(
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_arb (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req       (full_r),
        .advance   (state_r == ST_ARB),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Next-state logic plus the completion and error vectors.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = '0;
        err_nxt_s   = i_clr_err ? '0 : err_r;
        case (state_r)
            ST_IDLE: begin
                if (|full_r) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (zero_len_s) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = grant_s;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (resp_match_s) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = NUM_PE'(1) << cur_r;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_HALT;
                    err_nxt_s   = err_nxt_s | (NUM_PE'(1) << cur_r);
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_HALT: begin
                if (i_clr_err) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Descriptor slots: a full slot blocks new accepts until it is granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_r <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (i_req_valid[i] && ready_s[i]) begin
                    full_r[i] <= 1'b1;
                    slot_r[i] <= desc_in_s[i];
                end else if ((state_r == ST_ARB) && grant_s[i]) begin
                    full_r[i] <= 1'b0;
                end else begin
                    full_r[i] <= full_r[i];
                end
            end
        end
    end

    // Job datapath: latched descriptor, engine tag, watchdog, pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_desc_r <= '0;
            cur_r      <= '0;
            tag_r      <= 1'b0;
            wd_r       <= '0;
            done_r     <= '0;
            err_r      <= '0;
        end else begin
            done_r <= done_nxt_s;
            err_r  <= err_nxt_s;
            if (state_r == ST_ARB) begin
                out_desc_r <= slot_r[grant_idx_s];
                cur_r      <= grant_idx_s;
            end else begin
                out_desc_r <= out_desc_r;
                cur_r      <= cur_r;
            end
            // HALT resync aligns our tag with whatever the engine last reported.
            if (state_r == ST_ISSUE) begin
                tag_r <= ~tag_r;
            end else if ((state_r == ST_HALT) && i_clr_err) begin
                tag_r <= i_tag_resp_dDMA;
            end else begin
                tag_r <= tag_r;
            end
            if (state_r == ST_ISSUE) begin
                wd_r <= '0;
            end else if ((state_r == ST_WAIT) && !resp_match_s && (wd_r != {WD_W{1'b1}})) begin
                wd_r <= wd_r + WD_W'(1);
            end else begin
                wd_r <= wd_r;
            end
        end
    end

    assign o_req_ready      = ready_s;
    assign o_tag_start_dDMA = tag_r;
    assign o_addr_RAM       = out_desc_r.addr_ram;
    assign o_len_RAM        = out_desc_r.len_ram;
    assign o_addr_RAM_AIPE  = out_desc_r.addr_aipe;
    assign o_len_RAM_AIPE   = out_desc_r.len_aipe;
    assign o_dir            = out_desc_r.dir;
    assign o_done           = done_r;
    assign o_err_timeout    = err_r;
    assign d_state_3b       = state_r;
    assign d_cur_pe_2b      = 2'(cur_r);

endmodule
